lcd_hex_driver: RTL and testbench

LCD_HEX_DRIVER -- requirements
Module: lcd_hex_driver

---
 rtl/lcd_hex_driver.sv | 175 +++++++++++++++++
 tb/tb_lcd_hex_driver.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_hex_driver.sv
// HD44780 8-bit write-only driver: power-up wait, init commands, then endless two-row hex refresh.
// Each write is SETUP (1) / PULSE (EN_CYCLES) / HOLD (WAIT_CYCLES, or CLR_CYCLES after clear).
`timescale 1ns/1ps
module lcd_hex_driver #(
  parameter int PWRUP_CYCLES = 750000,
  parameter int EN_CYCLES    = 16,
  parameter int WAIT_CYCLES  = 2500,
  parameter int CLR_CYCLES   = 100000
) (
  input  logic        LHD_clk,
  input  logic        LHD_rst,
  input  logic [31:0] LHD_line1,
  input  logic [31:0] LHD_line2,
  input  logic [3:0]  LHD_sel,
  output logic [7:0]  LCD_DATA,
  output logic        LCD_RS,
  output logic        LCD_RW,
  output logic        LCD_EN,
  output logic        LCD_ON,
  output logic        LHD_ready,
  output logic        LHD_frame_done
);

  localparam int MAX_A   = (PWRUP_CYCLES > EN_CYCLES) ? PWRUP_CYCLES : EN_CYCLES;
  localparam int MAX_B   = (WAIT_CYCLES > CLR_CYCLES) ? WAIT_CYCLES : CLR_CYCLES;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [5:0]       LAST_STEP  = 6'd33;

  typedef enum logic [1:0] {PWRUP, INIT, FRAME} state_t;
  typedef enum logic [1:0] {SETUP, PULSE, HOLD} sub_t;

  state_t           state, state_nxt;
  sub_t             sub, sub_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, hold_last;
  logic [5:0]       step, step_nxt;
  logic [31:0]      snap_line1, snap_line2;
  logic [3:0]       snap_sel;
  logic [3:0]       col;
  logic [7:0]       wr_dat;
  logic             wr_rs;

  function automatic logic [7:0] nib2asc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  always_ff @(posedge LHD_clk or posedge LHD_rst) begin
    if (LHD_rst) begin
      state <= PWRUP;
      sub   <= SETUP;
      cnt   <= '0;
      step  <= '0;
    end else begin
      state <= state_nxt;
      sub   <= sub_nxt;
      cnt   <= cnt_nxt;
      step  <= step_nxt;
    end
  end

  // The clear command needs the long settle time.
  assign hold_last = (state == INIT && step == 6'd2) ? CLR_LAST : WAIT_LAST;

  always_comb begin
    state_nxt = state;
    sub_nxt   = sub;
    cnt_nxt   = cnt + CNT_ONE;
    step_nxt  = step;
    if (state == PWRUP) begin
      if (cnt == PWRUP_LAST) begin
        state_nxt = INIT;
        sub_nxt   = SETUP;
        cnt_nxt   = '0;
        step_nxt  = '0;
      end
    end else begin
      case (sub)
        SETUP: begin
          sub_nxt = PULSE;
          cnt_nxt = '0;
        end
        PULSE: begin
          if (cnt == EN_LAST) begin
            sub_nxt = HOLD;
            cnt_nxt = '0;
          end
        end
        HOLD: begin
          if (cnt == hold_last) begin
            sub_nxt = SETUP;
            cnt_nxt = '0;
            if (state == INIT) begin
              if (step == 6'd3) begin
                state_nxt = FRAME;
                step_nxt  = '0;
              end else begin
                step_nxt = step + 6'd1;
              end
            end else begin
              step_nxt = (step == LAST_STEP) ? 6'd0 : step + 6'd1;
            end
          end
        end
        default: begin
          sub_nxt = SETUP;
          cnt_nxt = '0;
        end
      endcase
    end
  end

  // Frame steps: 0 = 0x80, 1..16 = row 1, 17 = 0xC0, 18..33 = row 2.
  always_comb begin
    wr_dat = 8'h00;
    wr_rs  = 1'b0;
    col    = 4'd0;
    case (state)
      INIT: begin
        case (step[1:0])
          2'd0:    wr_dat = 8'h38;
          2'd1:    wr_dat = 8'h0C;
          2'd2:    wr_dat = 8'h01;
          default: wr_dat = 8'h06;
        endcase
      end
      FRAME: begin
        if (step == 6'd0) begin
          wr_dat = 8'h80;
        end else if (step == 6'd17) begin
          wr_dat = 8'hC0;
        end else if (step < 6'd17) begin
          wr_rs = 1'b1;
          col   = step[3:0] - 4'd1;
          if (!col[3])          wr_dat = nib2asc(snap_line1[{~col[2:0], 2'b00} +: 4]);
          else if (col == 4'hF) wr_dat = nib2asc(snap_sel);
          else                  wr_dat = 8'h20;
        end else begin
          wr_rs = 1'b1;
          col   = step[3:0] - 4'd2;
          if (!col[3]) wr_dat = nib2asc(snap_line2[{~col[2:0], 2'b00} +: 4]);
          else         wr_dat = 8'h20;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge LHD_clk or posedge LHD_rst) begin
    if (LHD_rst) begin
      snap_line1 <= '0;
      snap_line2 <= '0;
      snap_sel   <= '0;
    end else if (state == FRAME && sub == SETUP && step == 6'd0) begin
      snap_line1 <= LHD_line1;
      snap_line2 <= LHD_line2;
      snap_sel   <= LHD_sel;
    end
  end

  assign LCD_DATA       = wr_dat;
  assign LCD_RS         = wr_rs;
  assign LCD_RW         = 1'b0;
  assign LCD_EN         = (state != PWRUP) && (sub == PULSE);
  assign LCD_ON         = ~LHD_rst;
  assign LHD_ready      = (state == FRAME);
  assign LHD_frame_done = (state == FRAME) && (sub == HOLD) && (step == LAST_STEP) &&
                          (cnt == WAIT_LAST);

endmodule

// File: tb/tb_lcd_hex_driver.sv
// Directed bench for lcd_hex_driver with short timing parameters.
`timescale 1ns/1ps
module tb_lcd_hex_driver;
  localparam int PW = 10, EW = 2, WW = 3, CWC = 6;

  localparam logic [127:0] ROW1_A = 128'h31324142434445462020202020202037;
  localparam logic [127:0] ROW1_B = 128'h39383736353433302020202020202037;
  localparam logic [127:0] ROW2   = 128'h30303030303046392020202020202020;

  logic        LHD_clk = 1'b0;
  logic        LHD_rst = 1'b1;
  logic [31:0] LHD_line1, LHD_line2;
  logic [3:0]  LHD_sel;
  logic [7:0]  LCD_DATA;
  logic        LCD_RS, LCD_RW, LCD_EN, LCD_ON, LHD_ready, LHD_frame_done;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, cyc_rel = 0;
  int stable_bad = 0;
  int fd_cyc[$];
  int fd_run = 0, fd_maxw = 0;

  lcd_hex_driver #(
    .PWRUP_CYCLES(PW), .EN_CYCLES(EW), .WAIT_CYCLES(WW), .CLR_CYCLES(CWC)
  ) dut (
    .LHD_clk(LHD_clk), .LHD_rst(LHD_rst),
    .LHD_line1(LHD_line1), .LHD_line2(LHD_line2), .LHD_sel(LHD_sel),
    .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN),
    .LCD_ON(LCD_ON), .LHD_ready(LHD_ready), .LHD_frame_done(LHD_frame_done)
  );

  always #5 LHD_clk = ~LHD_clk;
  always @(posedge LHD_clk) cyc++;

  always @(negedge LHD_clk) begin
    if (LHD_frame_done === 1'b1) begin
      fd_run++;
      if (fd_run == 1) fd_cyc.push_back(cyc);
      if (fd_run > fd_maxw) fd_maxw = fd_run;
    end else begin
      fd_run = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] init_cmd(input int i);
    case (i)
      0:       return 8'h38;
      1:       return 8'h0C;
      2:       return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  // Waits (bounded) for an EN rise; optionally follows the pulse to its fall.
  task automatic get_write(input bit wait_fall, output logic [7:0] d, output logic rs,
                           output int t_rise, output int width);
    int n;
    d = '0; rs = 1'b0; t_rise = -1; width = 0; n = 0;
    do begin
      @(negedge LHD_clk);
      n++;
    end while (LCD_EN !== 1'b1 && n < 100);
    if (LCD_EN !== 1'b1) begin
      check("en_rise_timeout", {31'd0, LCD_EN}, 32'd1);
      return;
    end
    d = LCD_DATA; rs = LCD_RS; t_rise = cyc; width = 1;
    if (wait_fall) begin
      @(negedge LHD_clk);
      while (LCD_EN === 1'b1 && width < 50) begin
        if (LCD_DATA !== d || LCD_RS !== rs) stable_bad++;
        width++;
        @(negedge LHD_clk);
      end
      if (LCD_DATA !== d || LCD_RS !== rs) stable_bad++;
    end
  endtask

  task automatic run_init(input string tag);
    logic [7:0] d;
    logic rs;
    int t, w, tp;
    tp = 0;
    for (int i = 0; i < 4; i++) begin
      get_write(1'b1, d, rs, t, w);
      check({tag, "_cmd"}, {23'd0, rs, d}, {23'd0, 1'b0, init_cmd(i)});
      check({tag, "_en_width"}, w, EW);
      check({tag, "_rw"}, {31'd0, LCD_RW}, 32'd0);
      if (i == 0) check({tag, "_first_rise_edge"}, t - cyc_rel, 11);
      else        check({tag, "_gap"}, t - tp, (i == 3) ? 9 : 6);
      tp = t;
    end
    check({tag, "_ready_low_in_init"}, {31'd0, LHD_ready}, 32'd0);
    repeat (2) @(negedge LHD_clk);
    check({tag, "_ready_low_last_hold"}, {31'd0, LHD_ready}, 32'd0);
    @(negedge LHD_clk);
    check({tag, "_ready_high"}, {31'd0, LHD_ready}, 32'd1);
  endtask

  task automatic run_frame(input string tag, input logic [127:0] r1, input logic [127:0] r2,
                           input int chg_at, output int last_rise);
    logic [7:0] d;
    logic rs;
    logic [8:0] exp;
    int t, w, tp;
    tp = 0;
    last_rise = -1;
    for (int k = 0; k < 34; k++) begin
      get_write(1'b1, d, rs, t, w);
      if (k == 0)       exp = {1'b0, 8'h80};
      else if (k < 17)  exp = {1'b1, r1[8*(16-k) +: 8]};
      else if (k == 17) exp = {1'b0, 8'hC0};
      else              exp = {1'b1, r2[8*(33-k) +: 8]};
      check($sformatf("%s_w%0d", tag, k), {23'd0, rs, d}, {23'd0, exp});
      if (k > 0) check($sformatf("%s_gap%0d", tag, k), t - tp, 6);
      tp = t;
      if (k == chg_at) LHD_line1 = 32'h9876_5430;
      if (k == 33) last_rise = t;
    end
  endtask

  initial begin
    logic [7:0] d;
    logic rs;
    int t, w, lr1, lr2, lr3, f0, f1;

    LHD_line1 = 32'h12AB_CDEF;
    LHD_line2 = 32'h0000_00F9;
    LHD_sel   = 4'h7;
    LHD_rst   = 1'b1;
    repeat (3) @(negedge LHD_clk);
    check("reset_outputs",
          {18'd0, LCD_DATA, LCD_RS, LCD_RW, LCD_EN, LCD_ON, LHD_ready, LHD_frame_done}, 32'd0);

    LHD_rst = 1'b0;
    cyc_rel = cyc;
    #1;
    check("lcd_on_after_release", {31'd0, LCD_ON}, 32'd1);
    check("ready_after_release", {31'd0, LHD_ready}, 32'd0);

    run_init("init1");
    check("no_frame_done_in_init", fd_cyc.size(), 0);

    run_frame("f1", ROW1_A, ROW2, -1, lr1);
    run_frame("f2", ROW1_A, ROW2, 5, lr2);
    run_frame("f3", ROW1_B, ROW2, -1, lr3);

    f0 = (fd_cyc.size() > 0) ? fd_cyc[0] : -1000;
    f1 = (fd_cyc.size() > 1) ? fd_cyc[1] : -1000;
    check("frame_done_position", f0 - lr1, 4);
    check("frame_done_spacing", f1 - f0, 204);
    check("frame_done_width", fd_maxw, 1);
    check("data_stable_during_write", stable_bad, 0);

    get_write(1'b0, d, rs, t, w);
    check("pulse_before_reset", {31'd0, LCD_EN}, 32'd1);
    #2 LHD_rst = 1'b1;
    #1;
    check("en_drops_on_reset", {31'd0, LCD_EN}, 32'd0);
    check("outputs_zero_in_reset",
          {18'd0, LCD_DATA, LCD_RS, LCD_RW, LCD_EN, LCD_ON, LHD_ready, LHD_frame_done}, 32'd0);
    repeat (2) @(posedge LHD_clk);
    @(negedge LHD_clk);
    check("outputs_zero_held_reset",
          {18'd0, LCD_DATA, LCD_RS, LCD_RW, LCD_EN, LCD_ON, LHD_ready, LHD_frame_done}, 32'd0);

    LHD_rst = 1'b0;
    cyc_rel = cyc;
    #1;
    check("lcd_on_after_rerelease", {31'd0, LCD_ON}, 32'd1);
    check("ready_low_after_rerelease", {31'd0, LHD_ready}, 32'd0);
    run_init("init2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
